// File: rtl/regfile_pkg.sv
// Shared constants for the register-file execution controller: opcodes,
// FSM state encoding and instruction field positions.
package regfile_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_MAC = 4'd6;
    localparam logic [3:0] OP_LDI = 4'd7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    localparam int FIELD_W = 4;
    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 8;
    localparam int RS1_LSB = 4;
    localparam int RS2_LSB = 0;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 8;

    // Ops that read rs1/rs2 from the file and so need those addresses checked.
    function automatic logic uses_sources(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_MAC);
    endfunction

endpackage

// File: rtl/regfile_alu.sv
// Combinational ALU for the execution controller. Define SAT_ARITH_EN to make
// ADD/MAC clamp high and SUB clamp at zero, with o_ovf flagging the clamp.
module regfile_alu
    import regfile_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [3:0]   i_op,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    output logic [W-1:0] o_y,
    output logic         o_ovf
);

    logic [W:0]   w_sum;
    logic [W:0]   w_diff;
    logic [W-1:0] w_prod;
    logic [W:0]   w_mac;

    always_comb begin
        w_sum  = {1'b0, i_a} + {1'b0, i_b};
        w_diff = {1'b0, i_a} - {1'b0, i_b};
        w_prod = i_a * i_b;
        // MAC adds only the low W bits of the product to the accumulator.
        w_mac  = {1'b0, i_c} + {1'b0, w_prod};
        o_y    = '0;
        o_ovf  = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_y   = w_sum[W-1:0];
                o_ovf = w_sum[W];
            end
            OP_SUB: begin
                o_y   = w_diff[W-1:0];
                o_ovf = w_diff[W];
            end
            OP_AND: o_y = i_a & i_b;
            OP_OR:  o_y = i_a | i_b;
            OP_XOR: o_y = i_a ^ i_b;
            OP_MAC: begin
                o_y   = w_mac[W-1:0];
                o_ovf = w_mac[W];
            end
            default: begin
                o_y   = '0;
                o_ovf = 1'b0;
            end
        endcase
`ifdef SAT_ARITH_EN
        if (o_ovf) begin
            o_y = (i_op == OP_SUB) ? '0 : '1;
        end
`else
        o_ovf = 1'b0;
`endif
    end

endmodule

// File: rtl/regfile_exec_ctrl.sv
// Instruction sequencer around a 3-read/1-write register file: IDLE->READ->EXEC->WRITE.
// Optional SAT_ARITH_EN selects saturating ADD/SUB/MAC inside regfile_alu.
module regfile_exec_ctrl
    import regfile_pkg::*;
#(
    parameter int M = 4,
    parameter int N = 15,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [15:0]  instr,
    output logic         rf_read_en,
    output logic [M-1:0] rf_read_reg1,
    output logic [M-1:0] rf_read_reg2,
    output logic [M-1:0] rf_read_reg3,
    input  logic [W-1:0] rf_read_data1,
    input  logic [W-1:0] rf_read_data2,
    input  logic [W-1:0] rf_read_data3,
    output logic         rf_write_en,
    output logic [M-1:0] rf_write_reg,
    output logic [W-1:0] rf_write_data,
    output logic         done,
    output logic         err,
    output logic         ovf,
    output logic [W-1:0] result
);

    logic [1:0]         r_state;
    logic [3:0]         r_op;
    logic [M-1:0]       r_rd;

    logic               w_accept;
    logic               w_illegal;
    logic [3:0]         w_op;
    logic [FIELD_W-1:0] w_rd;
    logic [FIELD_W-1:0] w_rs1;
    logic [FIELD_W-1:0] w_rs2;
    logic [W-1:0]       w_imm;
    logic [W-1:0]       w_alu_y;
    logic               w_alu_ovf;

    assign instr_ready = (r_state == ST_IDLE);
    assign w_accept    = instr_valid & instr_ready;

    assign w_op  = instr[OP_LSB  +: 4];
    assign w_rd  = instr[RD_LSB  +: FIELD_W];
    assign w_rs1 = instr[RS1_LSB +: FIELD_W];
    assign w_rs2 = instr[RS2_LSB +: FIELD_W];
    assign w_imm = W'(instr[IMM_LSB +: IMM_W]);

    // rd is checked for every op, including NOP and LDI.
    assign w_illegal = (w_op > OP_LDI)
                    || (32'(w_rd) >= N)
                    || (uses_sources(w_op) && ((32'(w_rs1) >= N) || (32'(w_rs2) >= N)));

    regfile_alu #(
        .W(W)
    ) u_alu (
        .i_op  (r_op),
        .i_a   (rf_read_data1),
        .i_b   (rf_read_data2),
        .i_c   (rf_read_data3),
        .o_y   (w_alu_y),
        .o_ovf (w_alu_ovf)
    );

    // Strobes are set on the edge entering their state so they are high for that state's cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_op          <= OP_NOP;
            r_rd          <= '0;
            rf_read_en    <= 1'b0;
            rf_read_reg1  <= '0;
            rf_read_reg2  <= '0;
            rf_read_reg3  <= '0;
            rf_write_en   <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            ovf           <= 1'b0;
            result        <= '0;
        end else begin
            rf_read_en  <= 1'b0;
            rf_write_en <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            ovf         <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op <= w_op;
                        r_rd <= M'(w_rd);
                        if (w_illegal) begin
                            err <= 1'b1;
                        end else if (w_op == OP_NOP) begin
                            done <= 1'b1;
                        end else if (w_op == OP_LDI) begin
                            rf_write_en   <= 1'b1;
                            rf_write_reg  <= M'(w_rd);
                            rf_write_data <= w_imm;
                            result        <= w_imm;
                            done          <= 1'b1;
                            r_state       <= ST_WRITE;
                        end else begin
                            rf_read_en   <= 1'b1;
                            rf_read_reg1 <= M'(w_rs1);
                            rf_read_reg2 <= M'(w_rs2);
                            rf_read_reg3 <= M'(w_rd);
                            r_state      <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    rf_write_en   <= 1'b1;
                    rf_write_reg  <= r_rd;
                    rf_write_data <= w_alu_y;
                    result        <= w_alu_y;
                    ovf           <= w_alu_ovf;
                    done          <= 1'b1;
                    r_state       <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_exec_ctrl.sv
// Scoreboard bench for regfile_exec_ctrl: a register-file environment, an arithmetic
// reference model filling an expectation queue, and an independent output monitor.
module tb_regfile_exec_ctrl;

    localparam int M   = 4;
    localparam int N   = 15;
    localparam int W   = 8;
    localparam int MOD = 1 << W;
`ifdef SAT_ARITH_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         instr_valid = 1'b0;
    logic         instr_ready;
    logic [15:0]  instr = 16'h0000;
    logic         rf_read_en;
    logic [M-1:0] rf_read_reg1, rf_read_reg2, rf_read_reg3;
    logic [W-1:0] rf_read_data1, rf_read_data2, rf_read_data3;
    logic         rf_write_en;
    logic [M-1:0] rf_write_reg;
    logic [W-1:0] rf_write_data;
    logic         done, err, ovf;
    logic [W-1:0] result;

    always #5 clk = ~clk;

    regfile_exec_ctrl #(.M(M), .N(N), .W(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .rf_read_en    (rf_read_en),
        .rf_read_reg1  (rf_read_reg1),
        .rf_read_reg2  (rf_read_reg2),
        .rf_read_reg3  (rf_read_reg3),
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2),
        .rf_read_data3 (rf_read_data3),
        .rf_write_en   (rf_write_en),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .done          (done),
        .err           (err),
        .ovf           (ovf),
        .result        (result)
    );

    // Register file environment: registered read, write on strobe, seeded during reset.
    logic [W-1:0] rf_mem [16];
    logic [W-1:0] seed   [16];
    logic         seed_en = 1'b1;

    always @(posedge clk) begin
        if (seed_en) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= seed[i];
        end else begin
            if (rf_read_en) begin
                rf_read_data1 <= rf_mem[rf_read_reg1];
                rf_read_data2 <= rf_mem[rf_read_reg2];
                rf_read_data3 <= rf_mem[rf_read_reg3];
            end
            if (rf_write_en) rf_mem[rf_write_reg] <= rf_write_data;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;   // 0 write, 1 nop, 2 err
        int rd;
        int val;
        int ovf;
        int res;
        int due;
        logic [15:0] ins;
    } exp_t;

    exp_t sbq[$];
    int   ref_regs[16];
    int   last_result = 0;
    int   vectors = 0;
    int   miscompares = 0;

    function automatic void check(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    // Reference model: plain integer arithmetic on the architectural register values.
    function automatic void model(input logic [15:0] ins, input int acc, output exp_t e);
        int op  = int'(ins[15:12]);
        int rd  = int'(ins[11:8]);
        int rs1 = int'(ins[7:4]);
        int rs2 = int'(ins[3:0]);
        int a   = ref_regs[rs1];
        int b   = ref_regs[rs2];
        int c   = ref_regs[rd];
        int v   = 0;
        int o   = 0;
        e.ins = ins;
        e.rd  = rd;
        e.due = acc;
        e.val = 0;
        e.ovf = 0;
        if (op > 7 || rd >= N || (op >= 1 && op <= 6 && (rs1 >= N || rs2 >= N))) begin
            e.kind = 2;
        end else if (op == 0) begin
            e.kind = 1;
        end else begin
            e.kind = 0;
            case (op)
                1: v = a + b;
                2: v = a - b;
                3: v = a & b;
                4: v = a | b;
                5: v = a ^ b;
                6: v = c + ((a * b) % MOD);
                default: v = int'(ins[7:0]) % MOD;
            endcase
            if (v >= MOD) begin
                o = 1;
                v = SAT ? MOD - 1 : v - MOD;
            end else if (v < 0) begin
                o = 1;
                v = SAT ? 0 : v + MOD;
            end
            e.val = v;
            e.ovf = SAT ? o : 0;
            e.due = (op == 7) ? acc : acc + 2;
            ref_regs[rd] = v;
            last_result  = v;
        end
        e.res = last_result;
    endfunction

    task automatic issue(input logic [15:0] ins, output int acc);
        exp_t e;
        int   guard;
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        guard       = 0;
        while (!instr_ready && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        if (!instr_ready) begin
            miscompares++;
            $display("FAIL accept_timeout: instr %h not accepted, ready=%0d expected 1", ins, instr_ready);
            instr_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        model(ins, acc, e);
        sbq.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            instr_valid = 1'b0;
            instr       = 16'($urandom);
        end
    endtask

    task automatic drain();
        int guard = 0;
        idle(1);
        while ((sbq.size() != 0 || !instr_ready) && guard < 40) begin
            idle(1);
            guard++;
        end
        if (sbq.size() != 0 || !instr_ready) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d pending, ready=%0d expected 0 pending", sbq.size(), instr_ready);
            sbq.delete();
        end
    endtask

    // Monitor: pops one expectation per retirement/error event and compares.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rf_read_en && rf_write_en) begin
                    miscompares++;
                    $display("FAIL rw_overlap: read_en=1 write_en=1 expected never both");
                end
                if (ovf && !done) begin
                    miscompares++;
                    $display("FAIL ovf_without_done: ovf=1 done=0");
                end
                if (done || err || rf_write_en) begin
                    if (sbq.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_event: done=%0d err=%0d wen=%0d expected none", done, err, rf_write_en);
                    end else begin
                        e = sbq.pop_front();
                        $display("instr %h kind=%0d rd=%0d val=0x%0h ovf=%0d at cycle %0d",
                                 e.ins, e.kind, e.rd, e.val, e.ovf, cyc);
                        check("latency", cyc, e.due);
                        check("err", int'(err), (e.kind == 2) ? 1 : 0);
                        check("done", int'(done), (e.kind != 2) ? 1 : 0);
                        check("write_en", int'(rf_write_en), (e.kind == 0) ? 1 : 0);
                        if (e.kind == 0) begin
                            check("write_reg", int'(rf_write_reg), e.rd);
                            check("write_data", int'(rf_write_data), e.val);
                        end
                        check("ovf", int'(ovf), e.ovf);
                        check("result", int'(result), e.res);
                    end
                end
            end
        end
    end

    int acc_b2b [4];
    int acc_tmp;
    logic [15:0] b2b_ins [4];

    initial begin
        for (int i = 0; i < 16; i++) begin
            seed[i]     = W'($urandom_range(0, MOD - 1));
            ref_regs[i] = int'(seed[i]);
        end
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", int'(instr_ready), 1);
        check("rst_read_en", int'(rf_read_en), 0);
        check("rst_write_en", int'(rf_write_en), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_result", int'(result), 0);
        check("rst_wdata", int'(rf_write_data), 0);
        check("rst_raddr", int'(rf_read_reg1) | int'(rf_read_reg2) | int'(rf_read_reg3) | int'(rf_write_reg), 0);
        rst_n   = 1'b1;
        seed_en = 1'b0;
        idle(2);

        // Reset during EXEC: sequence abandoned, nothing written.
        @(negedge clk);
        instr = 16'h1412;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_write_en", int'(rf_write_en), 0);
        check("midrst_read_en", int'(rf_read_en), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_ready", int'(instr_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_ready", int'(instr_ready), 1);
        idle(4);

        // LDI r3,0x5A then ADD r4=r3+r3.
        issue(16'h735A, acc_tmp);
        issue(16'h1433, acc_tmp);
        drain();
        check("ldi_add_result", int'(result), 'hB4);

        // ADD 0xF0+0x20.
        issue(16'h75F0, acc_tmp);
        issue(16'h7620, acc_tmp);
        issue(16'h1756, acc_tmp);
        drain();
        check("add_wrap_sat", int'(result), SAT ? 'hFF : 'h10);

        // SUB 0x05-0x09.
        issue(16'h7805, acc_tmp);
        issue(16'h7909, acc_tmp);
        issue(16'h2A89, acc_tmp);
        drain();
        check("sub_wrap_sat", int'(result), SAT ? 'h00 : 'hFC);

        // MAC r2 = 3 + 4*5.
        issue(16'h7203, acc_tmp);
        issue(16'h7004, acc_tmp);
        issue(16'h7105, acc_tmp);
        issue(16'h6201, acc_tmp);
        @(negedge clk);
        instr_valid = 1'b0;
        check("mac_read_en", int'(rf_read_en), 1);
        check("mac_read_reg3", int'(rf_read_reg3), 2);
        check("mac_read_reg1", int'(rf_read_reg1), 0);
        check("mac_read_reg2", int'(rf_read_reg2), 1);
        drain();
        check("mac_result", int'(result), 'h17);

        // Illegal op and illegal source address.
        issue(16'h9000, acc_tmp);
        @(negedge clk);
        instr_valid = 1'b0;
        check("illegal_op_ready", int'(instr_ready), 1);
        check("illegal_op_err", int'(err), 1);
        issue(16'h112F, acc_tmp);
        @(negedge clk);
        instr_valid = 1'b0;
        check("illegal_rs2_ready", int'(instr_ready), 1);
        check("illegal_rs2_err", int'(err), 1);
        drain();

        // Back-to-back with valid held high.
        b2b_ins[0] = 16'h1123;
        b2b_ins[1] = 16'h5456;
        b2b_ins[2] = 16'h3789;
        b2b_ins[3] = 16'h4A01;
        for (int i = 0; i < 4; i++) issue(b2b_ins[i], acc_b2b[i]);
        drain();
        for (int i = 1; i < 4; i++) check("b2b_gap", acc_b2b[i] - acc_b2b[i-1], 4);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            issue({op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))}, acc_tmp);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        drain();
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
